// File: rtl/iir_chan_sched.sv
// iir_chan_sched: shared single-multiplier deemphasis IIR for two audio channels.
// Keeps per-channel x[n-1]/y[n-1] history and round-robins the left/right inputs.
module iir_chan_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int QBITS      = 10,
  parameter logic signed [DATA_WIDTH-1:0] B0 = 178,
  parameter logic signed [DATA_WIDTH-1:0] B1 = 178,
  parameter logic signed [DATA_WIDTH-1:0] A1 = 678
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            in_valid,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  output logic [1:0]            in_ready,
  input  logic                  hist_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_chan
);

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    OUT
  } state_t;

  localparam int PROD_WIDTH = DATA_WIDTH + QBITS;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   x_reg;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   x1 [0:1];
  logic [DATA_WIDTH-1:0]   y1 [0:1];
  logic                    chan;
  logic                    last_chan;

  logic                    grant_any;
  logic                    grant_chan;
  logic [DATA_WIDTH-1:0]   mul_coef;
  logic [DATA_WIDTH-1:0]   mul_opnd;
  logic [PROD_WIDTH-1:0]   coef_ext;
  logic [PROD_WIDTH-1:0]   opnd_ext;
  logic [PROD_WIDTH-1:0]   product;
  logic [DATA_WIDTH-1:0]   deq_prod;
  logic                    unused_frac_bits;

  // Round-robin grant: a lone requester wins, a tie goes to the channel not served last.
  always_comb begin
    grant_any  = (state == IDLE) && !hist_clr && !reset && (in_valid != 2'b00);
    grant_chan = (in_valid == 2'b11) ? ~last_chan : in_valid[1];
    in_ready   = 2'b00;
    if (grant_any) begin
      in_ready = grant_chan ? 2'b10 : 2'b01;
    end
  end

  // Operand mux and the one shared multiplier; only the bits surviving the dequantize shift are formed.
  always_comb begin
    mul_coef = B0;
    mul_opnd = x_reg;
    case (state)
      MUL1: begin
        mul_coef = B1;
        mul_opnd = x1[chan];
      end
      MUL2: begin
        mul_coef = A1;
        mul_opnd = y1[chan];
      end
      default: begin
        mul_coef = B0;
        mul_opnd = x_reg;
      end
    endcase
    coef_ext         = {{QBITS{mul_coef[DATA_WIDTH-1]}}, mul_coef};
    opnd_ext         = {{QBITS{mul_opnd[DATA_WIDTH-1]}}, mul_opnd};
    product          = coef_ext * opnd_ext;
    deq_prod         = product[PROD_WIDTH-1:QBITS];
    unused_frac_bits = ^product[QBITS-1:0];
  end

  // Scheduler FSM: accept, three multiply steps, then hold the result until downstream takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      x_reg     <= '0;
      acc       <= '0;
      x1[0]     <= '0;
      x1[1]     <= '0;
      y1[0]     <= '0;
      y1[1]     <= '0;
      chan      <= 1'b0;
      last_chan <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hist_clr) begin
            x1[0] <= '0;
            x1[1] <= '0;
            y1[0] <= '0;
            y1[1] <= '0;
          end else if (grant_any) begin
            x_reg <= grant_chan ? in_data_1 : in_data_0;
            chan  <= grant_chan;
            state <= MUL0;
          end
        end
        MUL0: begin
          acc   <= deq_prod;
          state <= MUL1;
        end
        MUL1: begin
          acc   <= acc + deq_prod;
          state <= MUL2;
        end
        MUL2: begin
          out_data  <= acc + deq_prod;
          out_chan  <= chan;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            x1[chan]  <= x_reg;
            y1[chan]  <= out_data;
            last_chan <= chan;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_chan_sched.sv
// tb_iir_chan_sched: directed self-checking bench for the shared IIR channel scheduler.
module tb_iir_chan_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  logic [31:0] in_data_0;
  logic [31:0] in_data_1;
  logic [1:0]  in_ready;
  logic        hist_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_chan;

  int checks = 0;
  int errors = 0;

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  iir_chan_sched dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .in_ready  (in_ready),
    .hist_clr  (hist_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  function automatic logic [31:0] deq(input logic signed [31:0] c, input logic signed [31:0] v);
    longint p;
    p = longint'(c) * longint'(v);
    p = p >>> 10;
    return p[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed timeout expected DUT event", tag);
  endtask

  // Offer one sample on a channel and return at the negedge after the accepting edge.
  task automatic applyStimulus(input int ch, input logic [31:0] x);
    int n;
    @(negedge clock);
    if (ch == 0) in_data_0 = x;
    else in_data_1 = x;
    in_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (in_ready[ch] !== 1'b1 && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 50) timeoutFail("grant");
    @(posedge clock);
    @(negedge clock);
    in_valid = 2'b00;
  endtask

  task automatic waitOutput(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 50) timeoutFail("out_valid");
  endtask

  task automatic takeOutput(input logic exp_chan, input logic [31:0] exp_data, input string tag);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_data"}, out_data, exp_data);
    checkOutput({tag, "_chan"}, {31'd0, out_chan}, {31'd0, exp_chan});
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic sample(input int ch, input logic [31:0] x, input logic [31:0] exp_data, input string tag);
    int lat;
    applyStimulus(ch, x);
    waitOutput(lat);
    checkOutput({tag, "_lat"}, lat, 32'd3);
    takeOutput(ch[0], exp_data, tag);
  endtask

  task automatic histClear();
    @(negedge clock);
    hist_clr = 1'b1;
    @(negedge clock);
    hist_clr = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [31:0] x1m, y1m, expv;
    int  viol, n_grant, n_out, bad_out;
    int  g_chan [0:3];
    int  g_cyc  [0:3];
    logic [31:0] o_data [0:3];
    logic        o_chan [0:3];

    reset     = 1'b1;
    hist_clr  = 1'b0;
    in_valid  = 2'b00;
    out_ready = 1'b0;
    in_data_0 = 32'd0;
    in_data_1 = 32'd0;

    // reset state
    repeat (2) @(negedge clock);
    in_valid  = 2'b11;
    in_data_0 = 32'd1024;
    in_data_1 = 32'd1024;
    #1;
    checkOutput("rst_in_ready", {30'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    in_valid = 2'b00;
    reset    = 1'b0;
    #1;
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_chan", {31'd0, out_chan}, 32'd0);
    checkOutput("rst_idle_ready", {30'd0, in_ready}, 32'd0);

    // basic filter and per-channel history
    sample(0, 32'd1024, 32'd178, "c0_first");
    sample(0, 32'd1024, 32'd473, "c0_second");
    sample(1, 32'd1024, 32'd178, "c1_first");
    sample(0, 32'd0,    32'd491, "c0_zero");

    // hist_clr wins over a pending request, then both histories are zero
    @(negedge clock);
    hist_clr  = 1'b1;
    in_data_0 = 32'd1024;
    in_valid  = 2'b01;
    #1;
    checkOutput("clr_blocks_ready", {30'd0, in_ready}, 32'd0);
    @(negedge clock);
    hist_clr = 1'b0;
    in_valid = 2'b00;
    sample(0, 32'd1024, 32'd178, "clr_c0");
    sample(1, 32'd1024, 32'd178, "clr_c1");

    // backpressure: hold for 10 cycles with the other channel requesting
    applyStimulus(0, 32'd1024);
    begin
      int lat;
      waitOutput(lat);
      checkOutput("stall_lat", lat, 32'd3);
    end
    in_data_1   = 32'd1024;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_data", out_data, 32'd473);
      checkOutput("stall_ready", {30'd0, in_ready}, 32'd0);
    end
    in_valid = 2'b00;
    takeOutput(1'b0, 32'd473, "stall_out");
    sample(1, 32'd1024, 32'd473, "stall_c1");
    sample(0, 32'd1024, 32'd669, "post_stall_c0");

    // negative input floors through the arithmetic shift
    histClear();
    sample(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "neg_one");

    // large input chain wraps modulo 2^32
    histClear();
    x1m = 32'd0;
    y1m = 32'd0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) expv = 32'd373293055;
      else if (i == 1) expv = 32'd993746941;
      else expv = deq(32'sd178, 32'h7FFF_FFFF) + deq(32'sd178, x1m) + deq(32'sd678, y1m);
      sample(0, 32'h7FFF_FFFF, expv, "wrap_chain");
      x1m = 32'h7FFF_FFFF;
      y1m = expv;
    end

    // reset during MUL1 drops the sample and clears history
    applyStimulus(0, 32'd1024);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_ready", {30'd0, in_ready}, 32'd0);
    reset   = 1'b0;
    bad_out = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) bad_out++;
    end
    checkOutput("mid_rst_no_out", bad_out, 32'd0);
    sample(0, 32'd1024, 32'd178, "post_rst_c0");

    // both channels requesting from reset: alternate 0,1,0,1 every 5 cycles
    doReset();
    viol    = 0;
    n_grant = 0;
    n_out   = 0;
    in_data_0 = 32'd1024;
    in_data_1 = 32'd1024;
    in_valid  = 2'b11;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (in_ready === 2'b11) viol++;
      if (in_ready !== 2'b00 && n_grant < 4) begin
        g_chan[n_grant] = (in_ready === 2'b10) ? 1 : 0;
        g_cyc[n_grant]  = cyc;
        n_grant++;
      end
      if (out_valid === 1'b1 && n_out < 4) begin
        o_data[n_out] = out_data;
        o_chan[n_out] = out_chan;
        n_out++;
      end
      @(negedge clock);
    end
    in_valid  = 2'b00;
    out_ready = 1'b0;
    checkOutput("rr_one_hot", viol, 32'd0);
    checkOutput("rr_grants", n_grant, 32'd4);
    checkOutput("rr_outs", n_out, 32'd4);
    if (n_grant == 4 && n_out == 4) begin
      checkOutput("rr_g0", g_chan[0], 32'd0);
      checkOutput("rr_g1", g_chan[1], 32'd1);
      checkOutput("rr_g2", g_chan[2], 32'd0);
      checkOutput("rr_g3", g_chan[3], 32'd1);
      for (int i = 1; i < 4; i++) checkOutput("rr_spacing", g_cyc[i] - g_cyc[i-1], 32'd5);
      checkOutput("rr_o0", o_data[0], 32'd178);
      checkOutput("rr_o1", o_data[1], 32'd178);
      checkOutput("rr_o2", o_data[2], 32'd473);
      checkOutput("rr_o3", o_data[3], 32'd473);
      checkOutput("rr_c0", {31'd0, o_chan[0]}, 32'd0);
      checkOutput("rr_c1", {31'd0, o_chan[1]}, 32'd1);
      checkOutput("rr_c2", {31'd0, o_chan[2]}, 32'd0);
      checkOutput("rr_c3", {31'd0, o_chan[3]}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
